mw_alu_seq: RTL and testbench
=============================

# mw_alu_seq

Multi-word arithmetic sequencer that sits in front of the 16-bit `ALU` and drives it as the initiator. It accepts a wide add/subtract request, issues one `ADD` per word from least to most significant word, and chains the carry through `IFlags`. It collects the `Y` words into a wide result and returns the result with aggregate `{V,N,C,Z}` flags over a valid/ready response channel.

## Interface
- `DataWidth`, 16: width of one ALU word.
- `Words`, 4: number of words per operand (≥1); full operand width is `W = DataWidth*Words`.
- `Clk` in 1: single clock, rising edge.
- `RstN` in 1: synchronous, active-low reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: sequencer can accept a request.
- `ReqOp` in 1: 0 = add (A+B), 1 = subtract (A−B).
- `ReqA` in W: operand A.
- `ReqB` in W: operand B.
- `RspValid` out 1: result available.
- `RspReady` in 1: consumer takes the result.
- `RspY` out W: result.
- `RspFlags` out 4: `{V,N,C,Z}`, with bit 0 = Z, bit 1 = C, bit 2 = N, bit 3 = V.

## Operation
- FSM states are IDLE, RUN and DONE.
  - Reset state is IDLE.
  - `ReqReady = (state==IDLE)`.
  - `RspValid = (state==DONE)`.
- IDLE to RUN happens on `ReqValid && ReqReady`. At that edge:
  - latch `ReqA`.
  - latch `ReqB`, or `~ReqB` when `ReqOp=1`.
  - set word index to 0.
  - set carry register to `ReqOp`, so subtract is A + ~B + 1.
  - set the zero accumulator to 1.
- RUN drives the ALU with:
  - `FuncOp = ADD`.
  - `A` = A word[idx].
  - `B` = (possibly inverted) B word[idx].
  - `IFlags = {2'b0, carry, 1'b0}`.
- Each RUN edge:
  - stores `Y` into result word[idx].
  - updates carry from `OFlags[1]`.
  - ANDs the zero accumulator with `OFlags[0]`.
  - increments idx.
- On the last word (`idx==Words-1`), the same edge:
  - captures `OFlags[3]` as V and `OFlags[2]` as N.
  - moves the FSM to DONE.
- The ALU `SUB` opcode is never used, because it ignores carry-in and cannot chain.
- Final flags:
  - Z = all words zero.
  - C = final carry-out. For subtract, C=1 means no borrow.
  - N = msb of result.
  - V = signed overflow of the top word.
- DONE to IDLE happens on `RspReady`. `RspY` and `RspFlags` are held stable while `RspValid && !RspReady`.
- A request arriving while not IDLE is not accepted; `ReqValid` stays pending, and there is no queueing.
- Reset, including mid-RUN or in DONE, aborts the operation. At the next edge, state = IDLE and all outputs return to reset values.

## Timing
- Reset values:
  - `ReqReady` = 1.
  - `RspValid` = 0.
  - `RspY` = 0.
  - `RspFlags` = 4'b0000.
- Accept edge is E0. RUN occupies the cycles after E0 through E(Words). `RspValid` is first high in the cycle after edge E(Words), so latency is Words+1 cycles from accept to `RspValid`.
- Minimum request spacing is Words+2 cycles, with an accept–response handshake in the same cycle as DONE exit; `ReqReady` rises the cycle after the response handshake.
- `Words=1` needs a single RUN cycle; N, V and C come from that one ALU op.
- All outputs are registered. The ALU path is combinational within one RUN cycle.

## Structure
- Opcode macros (`ADD`, `SUB`, …) and the flag bit indices (Zero=0, Carry=1, Neg=2, Over=3) come from the shared ALU definitions include/package. The FSM state encodings are added there as well.
- There is one sub-module: a single `ALU` instance with `DataWidth` and `FlagBits=4`, instantiated inside `mw_alu_seq`.
- Operand registers are addressed by word index. A right-shifting implementation is acceptable if behaviour is identical.

## Test plan
Directed tests use DataWidth=16 and Words=4.
- **Add with internal carry:** add `0x0000_0000_0000_FFFF` + `0x1` -> `RspY=0x0000_0000_0001_0000`, `RspFlags=4'b0000`.
- **Add wrapping to zero:** add `0xFFFF_FFFF_FFFF_FFFF` + `0x1` -> `RspY=0`, `RspFlags=4'b0011` (C, Z).
- **Subtract with borrow:** sub `0x5` − `0x7` -> `RspY=0xFFFF_FFFF_FFFF_FFFE`, `RspFlags=4'b0100`. Then sub `0x7` − `0x5` -> `0x2` with `4'b0010`.
- **Signed overflow:** add `0x7FFF_FFFF_FFFF_FFFF` + `0x1` -> `RspY=0x8000_0000_0000_0000`, `RspFlags=4'b1100`.
- **Backpressure:**
  - Hold `RspReady=0` for 10 cycles. `RspY`/`RspFlags` must stay stable, `ReqReady=0`, and a second pending request must not be accepted.
  - Release `RspReady`. `ReqReady=1` on the next cycle, then the second request is accepted.
- **Mid-operation reset:** drive `RstN=0` during RUN at idx=2. The next cycle shows `ReqReady=1`, `RspValid=0` and `RspY=0`, and no response appears afterwards.

Source files
------------

// File: rtl/mw_alu_seq_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and sequencer state encodings.
// Imported by the ALU, the sequencer and its interface users.
package mw_alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } aluOp_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVER  = 3;
  localparam int FLAG_BITS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seqState_e;

  function automatic logic [FLAG_BITS-1:0] packFlags(input logic v, input logic n,
                                                     input logic c, input logic z);
    return {v, n, c, z};
  endfunction

endpackage

// File: rtl/mw_alu_seq_if.sv
// Request/response bundle for the multi-word sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface mw_alu_seq_if #(
  parameter int DataWidth = 16,
  parameter int Words     = 4
);
  localparam int W = DataWidth * Words;

  logic         reqValid;
  logic         reqReady;
  logic         reqOp;
  logic [W-1:0] reqA;
  logic [W-1:0] reqB;
  logic         rspValid;
  logic         rspReady;
  logic [W-1:0] rspY;
  logic [3:0]   rspFlags;

  modport master (
    output reqValid, reqOp, reqA, reqB, rspReady,
    input  reqReady, rspValid, rspY, rspFlags
  );

  modport slave (
    input  reqValid, reqOp, reqA, reqB, rspReady,
    output reqReady, rspValid, rspY, rspFlags
  );

endinterface

// File: rtl/mw_alu_seq_alu.sv
// Single-word combinational ALU; ADD honours the carry-in flag, SUB does not.
// Output flags are {V,N,C,Z} at the positions defined in the package.
module ALU
  import mw_alu_seq_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int FlagBits  = 4
) (
  input  aluOp_e               i_funcOp,
  input  logic [DataWidth-1:0] i_a,
  input  logic [DataWidth-1:0] i_b,
  input  logic [FlagBits-1:0]  i_iFlags,
  output logic [DataWidth-1:0] o_y,
  output logic [FlagBits-1:0]  o_oFlags
);

  localparam int Msb = DataWidth - 1;

  logic [DataWidth:0]   w_sum;
  logic [DataWidth:0]   w_diff;
  logic [DataWidth-1:0] w_y;
  logic                 w_carry;
  logic                 w_over;
  logic                 w_unusedFlags;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{DataWidth{1'b0}}, i_iFlags[FLAG_CARRY]};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_unusedFlags = ^{i_iFlags[FlagBits-1:FLAG_CARRY+1], i_iFlags[FLAG_ZERO]};

  always_comb begin
    w_y     = i_a;
    w_carry = 1'b0;
    w_over  = 1'b0;
    case (i_funcOp)
      ALU_ADD: begin
        w_y     = w_sum[Msb:0];
        w_carry = w_sum[DataWidth];
        w_over  = (i_a[Msb] == i_b[Msb]) && (w_sum[Msb] != i_a[Msb]);
      end
      // Carry out of SUB means "no borrow", matching A + ~B + 1
      ALU_SUB: begin
        w_y     = w_diff[Msb:0];
        w_carry = ~w_diff[DataWidth];
        w_over  = (i_a[Msb] != i_b[Msb]) && (w_diff[Msb] != i_a[Msb]);
      end
      ALU_AND:  w_y = i_a & i_b;
      ALU_OR:   w_y = i_a | i_b;
      ALU_XOR:  w_y = i_a ^ i_b;
      ALU_PASS: w_y = i_a;
      default:  w_y = i_a;
    endcase
  end

  always_comb begin
    o_oFlags             = '0;
    o_oFlags[FLAG_ZERO]  = (w_y == '0);
    o_oFlags[FLAG_CARRY] = w_carry;
    o_oFlags[FLAG_NEG]   = w_y[Msb];
    o_oFlags[FLAG_OVER]  = w_over;
  end

  assign o_y = w_y;

endmodule

// File: rtl/mw_alu_seq.sv
// Multi-word add/subtract sequencer: one chained ALU ADD per word, LSW first,
// returning the wide result and aggregate {V,N,C,Z} flags on a valid/ready channel.
module mw_alu_seq
  import mw_alu_seq_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int Words     = 4
) (
  input  logic          i_clk,
  input  logic          i_rstN,
  mw_alu_seq_if.slave   bus
);

  localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  seqState_e r_state;
  seqState_e w_nextState;

  logic [Words-1:0][DataWidth-1:0] r_a;
  logic [Words-1:0][DataWidth-1:0] r_b;
  logic [Words-1:0][DataWidth-1:0] r_result;
  logic [IdxW-1:0]                 r_idx;
  logic                            r_carry;
  logic                            r_zero;
  logic [FLAG_BITS-1:0]            r_flags;

  aluOp_e                          w_aluOp;
  logic [DataWidth-1:0]            w_aluY;
  logic [FLAG_BITS-1:0]            w_aluIFlags;
  logic [FLAG_BITS-1:0]            w_aluFlags;
  logic                            w_accept;
  logic                            w_lastWord;

  assign w_accept    = bus.reqValid && (r_state == ST_IDLE);
  assign w_lastWord  = (r_idx == LastIdx);
  assign w_aluOp     = ALU_ADD;
  assign w_aluIFlags = {2'b00, r_carry, 1'b0};

  // SUB cannot chain a borrow, so subtraction is ADD of the inverted operand with carry-in 1
  ALU #(
    .DataWidth (DataWidth),
    .FlagBits  (FLAG_BITS)
  ) u_alu (
    .i_funcOp (w_aluOp),
    .i_a      (r_a[r_idx]),
    .i_b      (r_b[r_idx]),
    .i_iFlags (w_aluIFlags),
    .o_y      (w_aluY),
    .o_oFlags (w_aluFlags)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstN) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)     w_nextState = ST_RUN;
      ST_RUN:  if (w_lastWord)   w_nextState = ST_DONE;
      ST_DONE: if (bus.rspReady) w_nextState = ST_IDLE;
      default:                   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.reqA;
            r_b     <= bus.reqOp ? ~bus.reqB : bus.reqB;
            r_idx   <= '0;
            r_carry <= bus.reqOp;
            r_zero  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_result[r_idx] <= w_aluY;
          r_carry         <= w_aluFlags[FLAG_CARRY];
          r_zero          <= r_zero & w_aluFlags[FLAG_ZERO];
          r_idx           <= r_idx + 1'b1;
          // V and N come only from the most significant word
          if (w_lastWord) begin
            r_flags <= packFlags(w_aluFlags[FLAG_OVER], w_aluFlags[FLAG_NEG],
                                 w_aluFlags[FLAG_CARRY], r_zero & w_aluFlags[FLAG_ZERO]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reqReady = (r_state == ST_IDLE);
  assign bus.rspValid = (r_state == ST_DONE);
  assign bus.rspY     = r_result;
  assign bus.rspFlags = r_flags;

endmodule

// File: tb/tb_mw_alu_seq.sv
// Scoreboard bench for mw_alu_seq: stimulus pushes expected responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_mw_alu_seq;

  localparam int DataWidth = 16;
  localparam int Words     = 4;
  localparam int W         = DataWidth * Words;

  typedef struct packed {
    logic [W-1:0] y;
    logic [3:0]   flags;
  } expect_t;

  logic    clk = 1'b0;
  logic    rstN;
  int      compared = 0;
  int      mismatched = 0;
  expect_t sbQ[$];
  expect_t monE;

  mw_alu_seq_if #(.DataWidth(DataWidth), .Words(Words)) bus ();

  mw_alu_seq #(
    .DataWidth (DataWidth),
    .Words     (Words)
  ) dut (
    .i_clk  (clk),
    .i_rstN (rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rstN === 1'b1 && bus.rspValid === 1'b1 && bus.rspReady === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedRsp: got response 0x%h, expected none", bus.rspY);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("rspY", bus.rspY, monE.y);
        checkOutput("rspFlags", W'(bus.rspFlags), W'(monE.flags));
      end
    end
  end

  task automatic applyStimulus(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expY, input logic [3:0] expF, input bit track);
    bit accepted = 1'b0;
    bus.reqValid = 1'b1;
    bus.reqOp    = op;
    bus.reqA     = a;
    bus.reqB     = b;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (bus.reqReady === 1'b1) begin
        if (track) sbQ.push_back('{y: expY, flags: expF});
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    bus.reqValid = 1'b0;
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL acceptTimeout: got reqReady=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drainTimeout: got %0d outstanding, expected 0", sbQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  lat;
    bit  seen;

    bus.reqValid = 1'b0;
    bus.reqOp    = 1'b0;
    bus.reqA     = '0;
    bus.reqB     = '0;
    bus.rspReady = 1'b1;
    rstN         = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReqReady", W'(bus.reqReady), W'(1'b1));
    checkOutput("rstRspValid", W'(bus.rspValid), W'(1'b0));
    checkOutput("rstRspY", bus.rspY, '0);
    checkOutput("rstRspFlags", W'(bus.rspFlags), W'(4'b0000));
    @(posedge clk);
    #1;
    rstN = 1'b1;

    $display("[TB] add with internal carry, latency check");
    applyStimulus(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 4'b0000, 1'b1);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rspValid === 1'b1) seen = 1'b1;
    end
    checkOutput("latency", W'(lat), W'(Words + 1));
    waitDrain();

    $display("[TB] back-to-back directed vectors");
    applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0011, 1'b1);
    applyStimulus(1'b1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100, 1'b1);
    applyStimulus(1'b1, 64'h7, 64'h5, 64'h2, 4'b0010, 1'b1);
    applyStimulus(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1100, 1'b1);
    waitDrain();

    $display("[TB] backpressure with a pending second request");
    bus.rspReady = 1'b0;
    applyStimulus(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
                  64'h2345_6789_ABCD_F001, 4'b0000, 1'b1);
    bus.reqValid = 1'b1;
    bus.reqOp    = 1'b1;
    bus.reqA     = 64'h7;
    bus.reqB     = 64'h5;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rspValid === 1'b1) seen = 1'b1;
    end
    checkOutput("bpRspSeen", W'(seen), W'(1'b1));
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpRspY", bus.rspY, 64'h2345_6789_ABCD_F001);
      checkOutput("bpRspFlags", W'(bus.rspFlags), W'(4'b0000));
      checkOutput("bpReqReady", W'(bus.reqReady), W'(1'b0));
      checkOutput("bpRspValid", W'(bus.rspValid), W'(1'b1));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rspReady = 1'b1;
    @(negedge clk);
    checkOutput("bpReqReadyAtHandshake", W'(bus.reqReady), W'(1'b0));
    @(negedge clk);
    checkOutput("bpReqReadyAfter", W'(bus.reqReady), W'(1'b1));
    sbQ.push_back('{y: 64'h2, flags: 4'b0010});
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    waitDrain();

    $display("[TB] reset during RUN");
    applyStimulus(1'b0, 64'h1, 64'h2, 64'h0, 4'b0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("midRstReqReady", W'(bus.reqReady), W'(1'b1));
    checkOutput("midRstRspValid", W'(bus.rspValid), W'(1'b0));
    checkOutput("midRstRspY", bus.rspY, '0);
    checkOutput("midRstRspFlags", W'(bus.rspFlags), W'(4'b0000));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("midRstNoRsp", W'(bus.rspValid), W'(1'b0));
    end

    $display("[TB] operation after reset");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 64'h7, 64'h5, 64'h2, 4'b0010, 1'b1);
    waitDrain();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
